// File: rtl/branch_pkg.sv
// Shared encodings and defaults for the branch redirect sequencer.
package branch_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  localparam logic [3:0] LINK_REG_IDX         = 4'd14;
  localparam int         DEFAULT_FLUSH_CYCLES = 1;

endpackage

// File: rtl/flush_down_counter.sv
// 4-bit loadable down-counter with zero flag; holds at zero.
module flush_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= 4'd0;
    else if (load)                 count <= load_val;
    else if (dec && count != 4'd0) count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/branch_redirect_sequencer.sv
// Taken-branch front-end sequencer: PC redirect, IF/ID flush, one-shot BL link write.
// Optional BRANCH_STATS_EN adds saturating taken_cnt/link_cnt outputs.
module branch_redirect_sequencer
  import branch_pkg::*;
#(
  parameter int         ADDR_W       = 32,
  parameter int         FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter logic [3:0] LINK_REG     = LINK_REG_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              b_in,
  input  logic              cond_true_in,
  input  logic              bl_in,
  input  logic [ADDR_W-1:0] target_in,
  input  logic [ADDR_W-1:0] link_in,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_ifid,
  output logic              link_we,
  output logic [3:0]        link_addr,
  output logic [ADDR_W-1:0] link_data,
  output logic              busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       link_cnt
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]        state, state_nxt;
  logic              accept, cnt_load, cnt_dec, cnt_zero;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] tgt_q, lnk_q;
  logic              bl_q;

  flush_down_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // FLUSH exits on the edge where the counter reaches zero, so REDIRECT plus
  // FLUSH together span exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (b_in && cond_true_in && !stall_in) begin
          accept    = 1'b1;
          state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (!stall_in) begin
          cnt_load  = 1'b1;
          state_nxt = (FLUSH_LOAD == 4'd0) ? ST_IDLE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_dec = 1'b1;
        if (cnt_zero || cnt == 4'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tgt_q <= '0;
      lnk_q <= '0;
      bl_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tgt_q <= target_in;
        lnk_q <= link_in;
        bl_q  <= bl_in;
      end
    end
  end

  assign pc_load    = (state == ST_REDIRECT);
  assign flush_ifid = (state != ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign link_we    = (state == ST_REDIRECT) && bl_q && !stall_in;
  assign link_addr  = LINK_REG;
  assign pc_target  = tgt_q;
  assign link_data  = lnk_q;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= 16'd0;
      link_cnt  <= 16'd0;
    end else begin
      if (accept && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      if (link_we && link_cnt != 16'hFFFF) link_cnt  <= link_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_sequencer.sv
// Self-checking bench: two DUTs (FLUSH_CYCLES=1 and 3) on shared stimulus.
module tb_branch_redirect_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, b = 1'b0, cond = 1'b0, bl = 1'b0;
  logic [31:0] target = '0, link = '0;

  logic [1:0]       pl, fl, lw, bz;
  logic [1:0][31:0] pt, ld;
  logic [1:0][3:0]  la;
`ifdef BRANCH_STATS_EN
  logic [1:0][15:0] tc, lc;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_redirect_sequencer #(.ADDR_W(32), .FLUSH_CYCLES(1), .LINK_REG(4'd14)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall), .b_in(b), .cond_true_in(cond),
    .bl_in(bl), .target_in(target), .link_in(link), .pc_load(pl[0]),
    .pc_target(pt[0]), .flush_ifid(fl[0]), .link_we(lw[0]), .link_addr(la[0]),
    .link_data(ld[0]), .busy(bz[0])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc[0]), .link_cnt(lc[0])
`endif
  );

  branch_redirect_sequencer #(.ADDR_W(32), .FLUSH_CYCLES(3), .LINK_REG(4'd14)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall), .b_in(b), .cond_true_in(cond),
    .bl_in(bl), .target_in(target), .link_in(link), .pc_load(pl[1]),
    .pc_target(pt[1]), .flush_ifid(fl[1]), .link_we(lw[1]), .link_addr(la[1]),
    .link_data(ld[1]), .busy(bz[1])
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc[1]), .link_cnt(lc[1])
`endif
  );

  // Reference model: "in redirect" flag plus remaining post-redirect flush cycles.
  int          fc[2] = '{1, 3};
  bit          m_red[2];
  int          m_fl[2];
  logic [31:0] m_tgt[2], m_lnk[2];
  bit          m_bl[2];
  int          m_taken[2], m_links[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_red[i] = 0; m_fl[i] = 0; m_tgt[i] = '0; m_lnk[i] = '0; m_bl[i] = 0;
      m_taken[i] = 0; m_links[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (m_red[i]) begin
        if (!stall) begin
          if (m_bl[i]) m_links[i]++;
          m_red[i] = 0;
          m_fl[i]  = fc[i] - 1;
        end
      end else if (m_fl[i] > 0) begin
        m_fl[i]--;
      end else if (b && cond && !stall) begin
        m_red[i] = 1; m_tgt[i] = target; m_lnk[i] = link; m_bl[i] = bl;
        m_taken[i]++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic red, busy_e;
      red    = m_red[i];
      busy_e = m_red[i] || (m_fl[i] > 0);
      chk($sformatf("%s d%0d pc_load", tag, i),    32'(pl[i]), 32'(red));
      chk($sformatf("%s d%0d flush", tag, i),      32'(fl[i]), 32'(busy_e));
      chk($sformatf("%s d%0d busy", tag, i),       32'(bz[i]), 32'(busy_e));
      chk($sformatf("%s d%0d link_we", tag, i),    32'(lw[i]), 32'(red && m_bl[i] && !stall));
      chk($sformatf("%s d%0d pc_target", tag, i),  pt[i], m_tgt[i]);
      chk($sformatf("%s d%0d link_data", tag, i),  ld[i], m_lnk[i]);
      chk($sformatf("%s d%0d link_addr", tag, i),  32'(la[i]), 32'd14);
    end
  endtask

  task automatic apply(input logic s, input logic bb, input logic c, input logic l,
                       input logic [31:0] t, input logic [31:0] k);
    stall = s; b = bb; cond = c; bl = l; target = t; link = k;
  endtask

  // Called at a negedge with inputs already applied.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic s, bb, c, l;
    logic [31:0] t, k;
    logic pl, fl, lw, bz;
    logic [31:0] pt, ld;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic bb, input logic c, input logic l,
                              input logic [31:0] t, input logic [31:0] k,
                              input logic epl, input logic efl, input logic elw,
                              input logic [31:0] ept, input logic [31:0] eld);
    vec_t v;
    v.s = s; v.bb = bb; v.c = c; v.l = l; v.t = t; v.k = k;
    v.pl = epl; v.fl = efl; v.lw = elw; v.bz = efl; v.pt = ept; v.ld = eld;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    int n_fl, n_pl, n_lw;

    // Expected outputs of the FLUSH_CYCLES=1 instance, cycle by cycle.
    tbl[0]  = mk(0,1,1,0, 32'h100, 32'h0,  0,0,0, 32'h0,   32'h0);
    tbl[1]  = mk(0,0,0,0, 32'h0,   32'h0,  1,1,0, 32'h100, 32'h0);
    tbl[2]  = mk(0,0,0,0, 32'h0,   32'h0,  0,0,0, 32'h100, 32'h0);
    tbl[3]  = mk(0,1,1,1, 32'h200, 32'h24, 0,0,0, 32'h100, 32'h0);
    tbl[4]  = mk(0,0,0,0, 32'h0,   32'h0,  1,1,1, 32'h200, 32'h24);
    tbl[5]  = mk(0,0,0,0, 32'h0,   32'h0,  0,0,0, 32'h200, 32'h24);
    tbl[6]  = mk(0,1,1,1, 32'h300, 32'h30, 0,0,0, 32'h200, 32'h24);
    tbl[7]  = mk(1,0,0,0, 32'h0,   32'h0,  1,1,0, 32'h300, 32'h30);
    tbl[8]  = mk(1,0,0,0, 32'h0,   32'h0,  1,1,0, 32'h300, 32'h30);
    tbl[9]  = mk(1,0,0,0, 32'h0,   32'h0,  1,1,0, 32'h300, 32'h30);
    tbl[10] = mk(0,0,0,0, 32'h0,   32'h0,  1,1,1, 32'h300, 32'h30);
    tbl[11] = mk(0,0,0,0, 32'h0,   32'h0,  0,0,0, 32'h300, 32'h30);
    tbl[12] = mk(1,1,1,1, 32'h400, 32'h40, 0,0,0, 32'h300, 32'h30);
    tbl[13] = mk(0,0,1,1, 32'h500, 32'h50, 0,0,0, 32'h300, 32'h30);
    tbl[14] = mk(0,0,0,0, 32'h0,   32'h0,  0,0,0, 32'h300, 32'h30);

    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 15; r++) begin
      apply(tbl[r].s, tbl[r].bb, tbl[r].c, tbl[r].l, tbl[r].t, tbl[r].k);
      #1;
      chk($sformatf("tbl%0d pc_load", r),   32'(pl[0]), 32'(tbl[r].pl));
      chk($sformatf("tbl%0d flush", r),     32'(fl[0]), 32'(tbl[r].fl));
      chk($sformatf("tbl%0d link_we", r),   32'(lw[0]), 32'(tbl[r].lw));
      chk($sformatf("tbl%0d busy", r),      32'(bz[0]), 32'(tbl[r].bz));
      chk($sformatf("tbl%0d pc_target", r), pt[0], tbl[r].pt);
      chk($sformatf("tbl%0d link_data", r), ld[0], tbl[r].ld);
      check_model($sformatf("tbl%0d", r));
      tick();
    end

    // All eight b/cond/bl combinations from IDLE, with idle time to drain.
    for (int m = 0; m < 8; m++) begin
      apply(0, m[2], m[1], m[0], 32'h1000 + 32'(m), 32'h2000 + 32'(m));
      #1; check_model($sformatf("sweep%0d", m));
      tick();
      for (int j = 0; j < 4; j++) begin
        apply(0, 0, 0, 0, 32'h0, 32'h0);
        #1; check_model($sformatf("sweep%0d.%0d", m, j));
        tick();
      end
    end

    // Second taken branch during FLUSH of the 3-cycle instance is ignored.
    apply(0, 1, 1, 1, 32'hA000, 32'hA004);
    #1; check_model("ovl_acc");
    tick();
    n_fl = 0; n_pl = 0; n_lw = 0;
    for (int j = 0; j < 6; j++) begin
      if (j == 1 || j == 2) apply(0, 1, 1, 1, 32'hB000, 32'hB004);
      else                  apply(0, 0, 0, 0, 32'h0, 32'h0);
      #1; check_model($sformatf("ovl%0d", j));
      n_fl += int'(fl[1]); n_pl += int'(pl[1]); n_lw += int'(lw[1]);
      tick();
    end
    chk("ovl flush_cycles", 32'(n_fl), 32'd3);
    chk("ovl pc_loads",     32'(n_pl), 32'd1);
    chk("ovl link_writes",  32'(n_lw), 32'd1);
    chk("ovl target_kept",  pt[1], 32'hA000);

    // Randomised traffic against the model.
    for (int j = 0; j < 400; j++) begin
      apply($urandom_range(3) == 0, $urandom_range(2) != 0, $urandom_range(2) != 0,
            $urandom_range(1) == 1, $urandom, $urandom);
      #1; check_model($sformatf("rnd%0d", j));
      tick();
    end

    // Asynchronous reset in the middle of FLUSH.
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    for (int j = 0; j < 5; j++) tick();
    apply(0, 1, 1, 1, 32'hC000, 32'hC004);
    tick();
    apply(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    #1; chk("pre_rst in_flush", 32'(fl[1]), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef BRANCH_STATS_EN
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 1, (k != 1), 32'hD000 + 32'(k), 32'hE000 + 32'(k));
      tick();
      apply(0, 0, 0, 0, 32'h0, 32'h0);
      for (int j = 0; j < 5; j++) tick();
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stats d%0d taken", i), 32'(tc[i]), 32'd3);
      chk($sformatf("stats d%0d link", i),  32'(lc[i]), 32'd2);
      chk($sformatf("stats d%0d taken_m", i), 32'(tc[i]), 32'(m_taken[i]));
      chk($sformatf("stats d%0d link_m", i),  32'(lc[i]), 32'(m_links[i]));
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
